// File: rtl/prom_pkg.sv
// Shared widths and FSM encoding for the PROM access sequencer.
package prom_pkg;
  localparam int PROM_AW = 5;
  localparam int PROM_DW = 8;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/prom_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is taken.
module prom_rr_arb (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  // r_last_gnt1 = 1 means requester 1 was served last, so requester 0 wins a tie.
  logic r_last_gnt1;

  // one-hot grant from current requests and the round-robin pointer
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_last_gnt1 ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // round-robin pointer update
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last_gnt1 <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      r_last_gnt1 <= grant[1];
    end else begin
      r_last_gnt1 <= r_last_gnt1;
    end
  end
endmodule

// File: rtl/prom_arb_seq.sv
// Arbitrates two requesters onto a 32x8 PROM with a fixed chip-enable wait time.
module prom_arb_seq
  import prom_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req0,
  input  logic [PROM_AW-1:0] addr0,
  output logic               ack0,
  input  logic               req1,
  input  logic [PROM_AW-1:0] addr1,
  output logic               ack1,
  output logic [PROM_DW-1:0] rdata,
  output logic [PROM_AW-1:0] prom_a,
  output logic               prom_ce_n,
  input  logic [PROM_DW-1:0] prom_d,
  output logic               busy
);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [PROM_AW-1:0] r_prom_a, w_prom_a_nx;
  logic [PROM_DW-1:0] r_rdata, w_rdata_nx;
  logic [1:0]         r_gnt, w_gnt_nx, w_gnt;
  logic               r_ce_n, w_ce_n_nx;
  logic               r_ack0, w_ack0_nx;
  logic               r_ack1, w_ack1_nx;
  logic               r_busy;
  logic               w_advance;

  prom_rr_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({req1, req0}),
    .advance (w_advance),
    .grant   (w_gnt)
  );

  // next-state and next-output logic
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_prom_a_nx = r_prom_a;
    w_rdata_nx  = r_rdata;
    w_gnt_nx    = r_gnt;
    w_ce_n_nx   = r_ce_n;
    w_ack0_nx   = 1'b0;
    w_ack1_nx   = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0 || req1) begin
          w_advance   = 1'b1;
          w_gnt_nx    = w_gnt;
          w_prom_a_nx = w_gnt[1] ? addr1 : addr0;
          w_ce_n_nx   = 1'b0;
          w_cnt_nx    = CNT_LOAD;
          w_state_nx  = ST_ACCESS;
        end else begin
          w_ce_n_nx   = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (r_cnt != {CNT_W{1'b0}}) begin
          w_cnt_nx    = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          w_rdata_nx  = prom_d;
          w_ack0_nx   = r_gnt[0];
          w_ack1_nx   = r_gnt[1];
          w_ce_n_nx   = 1'b1;
          w_state_nx  = ST_DONE;
        end
      end
      ST_DONE: begin
        w_ce_n_nx  = 1'b1;
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_ce_n_nx  = 1'b1;
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // state and registered outputs; reset aborts any access without an ack
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= {CNT_W{1'b0}};
      r_prom_a <= {PROM_AW{1'b0}};
      r_rdata  <= {PROM_DW{1'b0}};
      r_gnt    <= 2'b00;
      r_ce_n   <= 1'b1;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_prom_a <= w_prom_a_nx;
      r_rdata  <= w_rdata_nx;
      r_gnt    <= w_gnt_nx;
      r_ce_n   <= w_ce_n_nx;
      r_ack0   <= w_ack0_nx;
      r_ack1   <= w_ack1_nx;
      r_busy   <= (w_state_nx != ST_IDLE);
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rdata     = r_rdata;
  assign prom_a    = r_prom_a;
  assign prom_ce_n = r_ce_n;
  assign busy      = r_busy;
endmodule

// File: tb/tb_prom_arb_seq.sv
// Directed bench: three instances (WAIT_CYCLES 2, 1, 15), each with its own PROM model.
module tb_prom_arb_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req0_s = 3'b000;
  logic [2:0] req1_s = 3'b000;
  logic [2:0] ack0_s, ack1_s, ce_n_s, busy_s;
  logic [4:0] addr0_s [3];
  logic [4:0] addr1_s [3];
  logic [4:0] prom_a_s [3];
  logic [7:0] rdata_s [3];
  logic [7:0] prom_d_s [3];

  int total = 0;
  int bad = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] prom_word(input logic [4:0] a);
    if (a == 5'h0A) return 8'h5C;
    return {a, 3'b000} ^ 8'hA5;
  endfunction

  function automatic int wc(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign prom_d_s[g] = ce_n_s[g] ? 8'hFF : prom_word(prom_a_s[g]);
    prom_arb_seq #(.WAIT_CYCLES((g == 0) ? 2 : ((g == 1) ? 1 : 15))) u_dut (
      .clk       (clk),
      .reset_n   (rst_n),
      .req0      (req0_s[g]),
      .addr0     (addr0_s[g]),
      .ack0      (ack0_s[g]),
      .req1      (req1_s[g]),
      .addr1     (addr1_s[g]),
      .ack1      (ack1_s[g]),
      .rdata     (rdata_s[g]),
      .prom_a    (prom_a_s[g]),
      .prom_ce_n (ce_n_s[g]),
      .prom_d    (prom_d_s[g]),
      .busy      (busy_s[g])
    );
  end

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) if (ack0_s[g] && ack1_s[g]) overlap++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic got_ack(input int d, input bit who);
    return who ? ack1_s[d] : ack0_s[d];
  endfunction

  // Called just after a negedge; runs one read and checks latency, address, data.
  task automatic read_op(input int d, input bit who, input logic [4:0] addr,
                         input logic [7:0] exp_d, input bit drop, output int hi);
    int  lat, lo;
    bit  seen, bad_a;
    if (who) begin req1_s[d] = 1'b1; addr1_s[d] = addr; end
    else     begin req0_s[d] = 1'b1; addr0_s[d] = addr; end
    hi = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ce_n_s[d] == 1'b0) seen = 1'b1; else hi++;
    end
    chk("grant_seen", {31'd0, seen}, 32'd1);
    lat = 0; lo = 0; bad_a = 1'b0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (ce_n_s[d] == 1'b0) begin
        lo++;
        if (prom_a_s[d] != addr || !busy_s[d]) bad_a = 1'b1;
      end
      if (got_ack(d, who)) seen = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    chk("ack_seen", {31'd0, seen}, 32'd1);
    chk("ack_latency", lat, wc(d));
    chk("ce_low_cycles", lo, wc(d));
    chk("addr_busy_held", {31'd0, bad_a}, 32'd0);
    chk("rdata", {24'd0, rdata_s[d]}, {24'd0, exp_d});
    chk("other_ack_low", {31'd0, got_ack(d, !who)}, 32'd0);
    if (drop) begin
      if (who) req1_s[d] = 1'b0; else req0_s[d] = 1'b0;
    end
  endtask

  typedef struct {
    bit         who;
    logic [4:0] addr;
    logic [7:0] data;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   hi, n;
    bit   seen, bad_a, ackx;
    logic [3:0] seq;

    vecs[0] = '{1'b0, 5'h0A, 8'h5C};
    vecs[1] = '{1'b1, 5'h00, 8'hA5};
    vecs[2] = '{1'b0, 5'h1F, 8'h5D};
    vecs[3] = '{1'b1, 5'h03, 8'hBD};
    vecs[4] = '{1'b1, 5'h15, 8'h0D};
    vecs[5] = '{1'b0, 5'h01, 8'hAD};
    for (int g = 0; g < 3; g++) begin addr0_s[g] = 5'h00; addr1_s[g] = 5'h00; end

    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_ce_n", {31'd0, ce_n_s[g]}, 32'd1);
      chk("rst_acks", {30'd0, ack1_s[g], ack0_s[g]}, 32'd0);
      chk("rst_busy", {31'd0, busy_s[g]}, 32'd0);
      chk("rst_rdata_a", {19'd0, rdata_s[g], prom_a_s[g]}, 32'd0);
    end
    rst_n = 1'b1;

    // both requesters from reset, held continuously: 0,1,0,1
    req0_s[0] = 1'b1; addr0_s[0] = 5'h01;
    req1_s[0] = 1'b1; addr1_s[0] = 5'h02;
    n = 0; seq = 4'h0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (ack0_s[0]) begin seq = {seq[2:0], 1'b0}; n++; end
      if (ack1_s[0]) begin seq = {seq[2:0], 1'b1}; n++; end
    end
    chk("rr_ack_count", n, 4);
    chk("rr_order", {28'd0, seq}, 32'h5);
    req0_s[0] = 1'b0; req1_s[0] = 1'b0;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 6; v++) read_op(0, vecs[v].who, vecs[v].addr, vecs[v].data, 1'b1, hi);

    // address change during ACCESS must not disturb the access
    req0_s[0] = 1'b1; addr0_s[0] = 5'h03;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ce_n_s[0] == 1'b0) seen = 1'b1;
    end
    addr0_s[0] = 5'h1F;
    bad_a = 1'b0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (ce_n_s[0] == 1'b0 && prom_a_s[0] != 5'h03) bad_a = 1'b1;
      if (ack0_s[0]) seen = 1'b1; else @(negedge clk);
    end
    chk("midaddr_ack", {31'd0, seen}, 32'd1);
    chk("midaddr_prom_a", {31'd0, bad_a}, 32'd0);
    chk("midaddr_rdata", {24'd0, rdata_s[0]}, 32'hBD);
    req0_s[0] = 1'b0;

    // reset in the middle of an access
    req0_s[0] = 1'b1; addr0_s[0] = 5'h0A;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ce_n_s[0] == 1'b0) seen = 1'b1;
    end
    chk("abort_started", {31'd0, seen}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ce_n", {31'd0, ce_n_s[0]}, 32'd1);
    chk("abort_ack", {31'd0, ack0_s[0]}, 32'd0);
    chk("abort_busy", {31'd0, busy_s[0]}, 32'd0);
    chk("abort_rdata", {24'd0, rdata_s[0]}, 32'd0);
    rst_n = 1'b1; req0_s[0] = 1'b0;
    ackx = 1'b0;
    repeat (4) begin @(negedge clk); if (ack0_s[0] || ack1_s[0]) ackx = 1'b1; end
    chk("abort_no_late_ack", {31'd0, ackx}, 32'd0);

    // latency sweep, back-to-back on WAIT_CYCLES=1
    read_op(1, 1'b0, 5'h07, 8'h9D, 1'b0, hi);
    read_op(1, 1'b0, 5'h10, 8'h25, 1'b1, hi);
    chk("deselect_gap", {31'd0, (hi >= 1)}, 32'd1);
    read_op(2, 1'b1, 5'h1F, 8'h5D, 1'b1, hi);
    read_op(2, 1'b0, 5'h00, 8'hA5, 1'b1, hi);

    repeat (2) @(negedge clk);
    chk("ack_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
